// File: rtl/acc_precond_pkg.sv
// Shared defaults and FSM state encoding for the accelerometer
// preconditioner feeding the madgwick normaliser.
package acc_precond_pkg;

  localparam int RAW_WIDTH_D  = 16;
  localparam int ACC_WIDTH_D  = 16;
  localparam int LOG2_AVG_D   = 2;
  localparam int GAIN_FRACT_D = 15;

  typedef enum logic [2:0] {
    ST_ACCUM,
    ST_ROUND,
    ST_SCALE,
    ST_HANDOFF,
    ST_RELEASE
  } state_e;

endpackage

// File: rtl/acc_precond_if.sv
// Raw-sample input handshake and normaliser start/done handoff.
// master = preconditioner side, slave = source/normaliser side.
interface acc_precond_if
  import acc_precond_pkg::*;
#(
  parameter int RAW_WIDTH = RAW_WIDTH_D,
  parameter int ACC_WIDTH = ACC_WIDTH_D
);

  logic                   raw_valid;
  logic                   raw_ready;
  logic [3*RAW_WIDTH-1:0] raw_data;
  logic                   start;
  logic                   done;
  logic [3*ACC_WIDTH-1:0] data_out;
  logic                   zero_drop;

  modport master (
    input  raw_valid,
    input  raw_data,
    input  done,
    output raw_ready,
    output start,
    output data_out,
    output zero_drop
  );

  modport slave (
    output raw_valid,
    output raw_data,
    output done,
    input  raw_ready,
    input  start,
    input  data_out,
    input  zero_drop
  );

endinterface

// File: rtl/acc_axis_scale.sv
// One axis: round-half-up average (registered), then signed gain
// multiply, fractional shift and saturation to ACC_WIDTH.
module acc_axis_scale #(
  parameter int ACCW       = 19,
  parameter int LOG2_AVG   = 2,
  parameter int GAIN_FRACT = 15,
  parameter int ACC_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        round_en_i,
  input  logic signed [ACCW-1:0]      acc_i,
  input  logic [15:0]                 gain_i,
  output logic signed [ACC_WIDTH-1:0] sat_o
);

  localparam int AVGW = ACCW + 1;
  localparam int PW   = AVGW + 17;

  localparam logic signed [AVGW-1:0] HALF =
    AVGW'(1) <<< (LOG2_AVG - 1);
  localparam logic signed [PW-1:0] MAXV =
    {{(PW-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] MINV =
    {{(PW-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};

  logic signed [AVGW-1:0] rnd;
  logic signed [AVGW-1:0] avg_q;
  logic signed [PW-1:0]   a_x;
  logic signed [PW-1:0]   g_x;
  logic signed [PW-1:0]   prod;
  logic signed [PW-1:0]   sh;

  assign rnd = AVGW'(acc_i) + HALF;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avg_q <= '0;
    end else if (round_en_i) begin
      avg_q <= rnd >>> LOG2_AVG;
    end
  end

  // gain is unsigned, so widen with a zero sign bit
  assign a_x  = PW'(avg_q);
  assign g_x  = PW'($signed({1'b0, gain_i}));
  assign prod = a_x * g_x;
  assign sh   = prod >>> GAIN_FRACT;

  always_comb begin
    sat_o = sh[ACC_WIDTH-1:0];
    if (sh > MAXV) begin
      sat_o = MAXV[ACC_WIDTH-1:0];
    end else if (sh < MINV) begin
      sat_o = MINV[ACC_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/acc_precond.sv
// Accelerometer preconditioner: bias removal, block averaging,
// gain scaling and saturation, then start/done handoff downstream.
module acc_precond
  import acc_precond_pkg::*;
#(
  parameter int RAW_WIDTH  = RAW_WIDTH_D,
  parameter int ACC_WIDTH  = ACC_WIDTH_D,
  parameter int LOG2_AVG   = LOG2_AVG_D,
  parameter int GAIN_FRACT = GAIN_FRACT_D
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [3*RAW_WIDTH-1:0] bias,
  input  logic [15:0]            gain,
  acc_precond_if.master          bus
);

  localparam int ACCW = RAW_WIDTH + 1 + LOG2_AVG;
  localparam int DW   = RAW_WIDTH + 1;

  typedef logic signed [ACCW-1:0] acc_t;

  state_e                 state_q, state_d;
  logic                   run_q;
  logic [LOG2_AVG-1:0]    cnt_q, cnt_d;
  acc_t                   acc_q [3];
  acc_t                   acc_d [3];
  logic [3*RAW_WIDTH-1:0] bias_q, bias_d;
  logic [15:0]            gain_q, gain_d;
  logic [3*ACC_WIDTH-1:0] dout_q, dout_d;
  logic                   zero_q, zero_d;
  logic                   round_en;
  logic                   take;
  logic                   first;
  logic [3*RAW_WIDTH-1:0] bias_use;
  logic [3*DW-1:0]        diff_w;
  logic [3*ACC_WIDTH-1:0] sat_w;

  assign take     = bus.raw_valid && bus.raw_ready;
  assign first    = take && (cnt_q == '0);
  // first sample of a window must already see the live bias
  assign bias_use = first ? bias : bias_q;

  for (genvar a = 0; a < 3; a++) begin : g_ax
    logic signed [RAW_WIDTH-1:0] r;
    logic signed [RAW_WIDTH-1:0] b;
    assign r = bus.raw_data[a*RAW_WIDTH +: RAW_WIDTH];
    assign b = bias_use[a*RAW_WIDTH +: RAW_WIDTH];
    assign diff_w[a*DW +: DW] = DW'(r) - DW'(b);

    acc_axis_scale #(
      .ACCW       (ACCW),
      .LOG2_AVG   (LOG2_AVG),
      .GAIN_FRACT (GAIN_FRACT),
      .ACC_WIDTH  (ACC_WIDTH)
    ) u_scale (
      .clk        (clk),
      .rst_n      (rst_n),
      .round_en_i (round_en),
      .acc_i      (acc_q[a]),
      .gain_i     (gain_q),
      .sat_o      (sat_w[a*ACC_WIDTH +: ACC_WIDTH])
    );
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bias_d   = bias_q;
    gain_d   = gain_q;
    dout_d   = dout_q;
    zero_d   = 1'b0;
    round_en = 1'b0;
    for (int a = 0; a < 3; a++) acc_d[a] = acc_q[a];

    unique case (state_q)
      ST_ACCUM: begin
        if (take) begin
          if (first) begin
            bias_d = bias;
            gain_d = gain;
          end
          for (int a = 0; a < 3; a++) begin
            acc_d[a] = acc_q[a] +
              ACCW'($signed(diff_w[a*DW +: DW]));
          end
          cnt_d = cnt_q + 1'b1;
          if (&cnt_q) state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        round_en = 1'b1;
        state_d  = ST_SCALE;
      end
      ST_SCALE: begin
        if (sat_w == '0) begin
          zero_d  = 1'b1;
          for (int a = 0; a < 3; a++) acc_d[a] = '0;
          state_d = ST_ACCUM;
        end else begin
          dout_d  = sat_w;
          state_d = ST_HANDOFF;
        end
      end
      ST_HANDOFF: begin
        if (bus.done) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!bus.done) begin
          for (int a = 0; a < 3; a++) acc_d[a] = '0;
          state_d = ST_ACCUM;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACCUM;
      run_q   <= 1'b0;
      cnt_q   <= '0;
      bias_q  <= '0;
      gain_q  <= '0;
      dout_q  <= '0;
      zero_q  <= 1'b0;
      for (int a = 0; a < 3; a++) acc_q[a] <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      cnt_q   <= cnt_d;
      bias_q  <= bias_d;
      gain_q  <= gain_d;
      dout_q  <= dout_d;
      zero_q  <= zero_d;
      for (int a = 0; a < 3; a++) acc_q[a] <= acc_d[a];
    end
  end

  // run_q holds ready low through reset and until the first edge
  assign bus.raw_ready = run_q && (state_q == ST_ACCUM);
  assign bus.start     = (state_q == ST_HANDOFF);
  assign bus.data_out  = dout_q;
  assign bus.zero_drop = zero_q;

endmodule

// File: tb/tb_acc_precond.sv
// Directed-vector bench for acc_precond.
// Inputs change on negedge, outputs sampled on negedge.
module tb_acc_precond;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [47:0] bias;
  logic [15:0] gain;
  int          checks = 0;
  int          errors = 0;

  acc_precond_if #(.RAW_WIDTH(16), .ACC_WIDTH(16)) bus_if ();

  acc_precond u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bias  (bias),
    .gain  (gain),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] vec(input int x,
                                      input int y,
                                      input int z);
    return {16'(z), 16'(y), 16'(x)};
  endfunction

  // returns at the negedge right after the accepting edge
  task automatic send(input int x, input int y, input int z);
    int n = 0;
    bus_if.raw_data  = vec(x, y, z);
    bus_if.raw_valid = 1'b1;
    while (!bus_if.raw_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", bus_if.raw_ready, 1);
    @(negedge clk);
    bus_if.raw_valid = 1'b0;
  endtask

  task automatic lat_chk(input string tag);
    chk({tag, "_lat1"}, bus_if.start, 0);
    @(negedge clk);
    chk({tag, "_lat2"}, bus_if.start, 0);
    @(negedge clk);
    chk({tag, "_lat3"}, bus_if.start, 1);
  endtask

  task automatic release_hs(input string tag);
    bus_if.done = 1'b1;
    @(negedge clk);
    chk({tag, "_start_fall"}, bus_if.start, 0);
    chk({tag, "_rdy_rel"}, bus_if.raw_ready, 0);
    @(negedge clk);
    chk({tag, "_rdy_hold"}, bus_if.raw_ready, 0);
    bus_if.done = 1'b0;
    @(negedge clk);
    chk({tag, "_rdy_back"}, bus_if.raw_ready, 1);
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_rdy"}, bus_if.raw_ready, 0);
    chk({tag, "_start"}, bus_if.start, 0);
    chk({tag, "_zd"}, bus_if.zero_drop, 0);
    chk({tag, "_dout"}, bus_if.data_out, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bus_if.raw_valid = 1'b0;
    bus_if.raw_data  = '0;
    bus_if.done      = 1'b0;
    bias  = '0;
    gain  = 16'h8000;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_chk("rst");
    rst_n = 1'b1;
    #1;
    chk("rdy_pre_edge", bus_if.raw_ready, 0);
    @(negedge clk);
    chk("rdy_rise", bus_if.raw_ready, 1);

    // unity gain averaging, then a long done=0 hold
    repeat (4) send(1000, -500, 4096);
    lat_chk("unity");
    chk("unity_dout", bus_if.data_out, vec(1000, -500, 4096));
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus_if.start !== 1'b1) ok = 1'b0;
      if (bus_if.raw_ready !== 1'b0) ok = 1'b0;
      if (bus_if.data_out !== vec(1000, -500, 4096)) ok = 1'b0;
    end
    chk("hold_stable", ok, 1);
    release_hs("unity");

    // half gain with round-half-up: avg(1,2,2,2)=2 -> 1
    gain = 16'h4000;
    send(1, 0, 0);
    repeat (3) send(2, 0, 0);
    lat_chk("half");
    chk("half_dout", bus_if.data_out, vec(1, 0, 0));
    release_hs("half");

    // done already high when handoff begins
    repeat (3) send(1000, 0, 0);
    bus_if.done = 1'b1;
    send(1000, 0, 0);
    lat_chk("early");
    chk("early_dout", bus_if.data_out, vec(500, 0, 0));
    @(negedge clk);
    chk("early_start_fall", bus_if.start, 0);
    bus_if.done = 1'b0;
    @(negedge clk);
    chk("early_rdy_back", bus_if.raw_ready, 1);

    // positive and negative saturation
    gain = 16'hFFFF;
    bias = vec(-32768, 0, 0);
    repeat (4) send(32767, 0, 0);
    lat_chk("satp");
    chk("satp_dout", bus_if.data_out, vec(32767, 0, 0));
    release_hs("satp");
    bias = vec(32767, 0, 0);
    repeat (4) send(-32768, 0, 0);
    lat_chk("satn");
    chk("satn_dout", bus_if.data_out, vec(-32768, 0, 0));
    release_hs("satn");

    // samples equal to bias: dropped, data_out kept
    gain = 16'h8000;
    bias = vec(5, -7, 3);
    repeat (4) send(5, -7, 3);
    chk("zero_l1", bus_if.zero_drop, 0);
    @(negedge clk);
    chk("zero_l2", bus_if.zero_drop, 0);
    @(negedge clk);
    chk("zero_pulse", bus_if.zero_drop, 1);
    chk("zero_start", bus_if.start, 0);
    chk("zero_rdy", bus_if.raw_ready, 1);
    chk("zero_dout", bus_if.data_out, vec(-32768, 0, 0));
    @(negedge clk);
    chk("zero_pulse_end", bus_if.zero_drop, 0);
    chk("zero_start2", bus_if.start, 0);

    // nonzero average scaled to zero is also dropped
    bias = '0;
    gain = 16'h0001;
    repeat (4) send(100, 200, 50);
    repeat (2) @(negedge clk);
    chk("tiny_pulse", bus_if.zero_drop, 1);
    chk("tiny_start", bus_if.start, 0);
    @(negedge clk);

    // reset mid-window discards partial sums
    gain = 16'h8000;
    repeat (2) send(7000, 7000, 7000);
    rst_n = 1'b0;
    #1;
    rst_chk("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_start", bus_if.start, 0);
    repeat (4) send(100, 200, 300);
    lat_chk("fresh");
    chk("fresh_dout", bus_if.data_out, vec(100, 200, 300));
    release_hs("fresh");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/acc_precond.md
ACC_PRECOND -- requirements
Module: acc_precond

Interface
REQ-001 The block SHALL have parameter RAW_WIDTH, default 16, giving the signed width of each raw accelerometer axis sample.
REQ-002 The block SHALL have parameter ACC_WIDTH, default 16, giving the signed fixed-point width of each output axis; this matches the downstream normaliser width.
REQ-003 The block SHALL have parameter LOG2_AVG, default 2, giving log2 of the number of samples averaged per output vector; legal range is 1..4.
REQ-004 The block SHALL have parameter GAIN_FRACT, default 15, giving the number of fractional bits in gain.
REQ-005 clk  in  1  clock; all state is updated on the rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 raw_valid  in  1  a raw sample is present on raw_data.
REQ-008 raw_ready  out  1  the block accepts a raw sample this cycle.
REQ-009 raw_data  in  3*RAW_WIDTH  packed signed raw sample {z,y,x}, with x in the LSBs.
REQ-010 bias  in  3*RAW_WIDTH  packed signed per-axis offset {z,y,x}; quasi-static.
REQ-011 gain  in  16  unsigned gain in UQ1.GAIN_FRACT, shared by all axes; quasi-static.
REQ-012 start  out  1  request to the downstream normaliser; held high until done.
REQ-013 done  in  1  completion flag from the downstream normaliser.
REQ-014 data_out  out  3*ACC_WIDTH  packed signed conditioned vector {z,y,x}.
REQ-015 zero_drop  out  1  one-cycle pulse when an all-zero vector is discarded.

Function
REQ-016 The FSM SHALL have the states ACCUM, ROUND, SCALE, HANDOFF and RELEASE; the reset state SHALL be ACCUM.
REQ-017 In ACCUM, raw_ready SHALL be 1; in every other state raw_ready SHALL be 0.
REQ-018 On the first accepted sample of a window (raw_valid && raw_ready), bias and gain SHALL be captured into registers; these captured values SHALL be used for the whole window.
REQ-019 Each accepted sample SHALL add (raw - bias) per axis into a signed accumulator of RAW_WIDTH+1+LOG2_AVG bits; this width guarantees no overflow.
REQ-020 A sample counter of LOG2_AVG bits SHALL count accepted samples; when the 2^LOG2_AVG-th sample is accepted, the counter SHALL wrap to 0 and the next state SHALL be ROUND.
REQ-021 ROUND (1 cycle) SHALL compute avg = (acc + 2^(LOG2_AVG-1)) >>> LOG2_AVG, using an arithmetic shift (round half up).
REQ-022 SCALE (1 cycle) SHALL compute prod = avg * gain as a signed product, then (prod >>> GAIN_FRACT), saturated to the signed ACC_WIDTH range [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1], and register the result into data_out.
REQ-023 After SCALE, if all three saturated axes are 0, the block SHALL pulse zero_drop for 1 cycle, clear the accumulators, leave data_out unchanged, and return to ACCUM.
REQ-024 Otherwise the block SHALL enter HANDOFF with start=1.
REQ-025 Latency from the last accepted sample to start rising SHALL be exactly 3 cycles.
REQ-026 In HANDOFF, start and data_out SHALL be held stable until done=1 is sampled; the block SHALL then enter RELEASE with start=0.
REQ-027 In RELEASE, the block SHALL wait until done=0 is sampled, then clear the accumulators and enter ACCUM.
REQ-028 If done is already 1 on HANDOFF entry, the block SHALL stay in HANDOFF for at least 1 cycle before moving to RELEASE.
REQ-029 raw_valid asserted outside ACCUM SHALL have no effect; the source holds the sample until raw_ready is 1.
REQ-030 The zero test SHALL be applied after saturation.

Reset
REQ-031 While rst_n=0, the outputs SHALL be: raw_ready=0, start=0, zero_drop=0, data_out=0.
REQ-032 While rst_n=0, the accumulators, sample counter, captured bias and captured gain SHALL be 0, and the state SHALL be ACCUM.
REQ-033 raw_ready SHALL rise on the first clock edge after rst_n is released.
REQ-034 A reset asserted mid-window or mid-handoff SHALL discard all partial data; there SHALL be no pending start after release.

Structure
REQ-035 The FSM state enum and the parameter defaults (RAW_WIDTH, ACC_WIDTH, LOG2_AVG, GAIN_FRACT) SHALL live in the shared madgwick defines/package.
REQ-036 A single sub-module, acc_axis_scale, SHALL be instantiated three times; it performs the round, shift, multiply and saturate for one axis.

Verification
REQ-037 Scenario (gain and averaging): LOG2_AVG=2, bias 0, gain 0x8000, four samples x=1000, y=-500, z=4096 -> data_out {4096,-500,1000}; start rises 3 cycles after the fourth sample is accepted.
REQ-038 Scenario (half gain and rounding): gain 0x4000; x samples 1,2,2,2 -> avg 2 and x_out 1. Same gain; x samples 1000 x4 -> x_out 500.
REQ-039 Scenario (saturation): raw 32767 with bias -32768 and gain 0xFFFF -> x_out 32767. Raw -32768 with bias 32767 -> x_out -32768.
REQ-040 Scenario (zero vector): all samples equal to bias -> zero_drop pulses once, start stays 0, raw_ready returns to 1 the next cycle.
REQ-041 Scenario (handshake): done held 0 for 20 cycles -> start and data_out stay stable. Then done=1 -> start falls. raw_ready stays 0 until done=0.
REQ-042 Scenario (reset mid-operation): rst_n pulsed after 2 of 4 samples -> all outputs 0. A fresh 4-sample window then produces the correct result, with no leftover contribution from the first 2 samples.
